sig_addr_gen: RTL

SIG_ADDR_GEN -- requirements
Module: sig_addr_gen

---
 rtl/sig_gen_pkg.sv | 22 ++
 rtl/sig_addr_gen_chan_offset.sv | 37 +++
 rtl/sig_addr_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/sig_gen_pkg.sv
// Shared types for the signal address generator: step modes, bounce direction
// and the width helper used for the channel-select port.
package sig_gen_pkg;

  typedef enum logic [1:0] {
    UP     = 2'b00,
    DOWN   = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_addr_gen_chan_offset.sv
// One output channel: offset register plus registered address = count + offset.
// Address trails count by one cycle; a new offset shows up one cycle after its write.
module chan_offset #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] addr
);

  logic [WIDTH-1:0] off_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] addr_d;

  // Uses the offset held this cycle, so a same-cycle write lands one cycle later.
  always_comb begin
    addr_d = count + off_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
      if (we) begin
        off_q <= wdata;
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/sig_addr_gen.sv
// Phase accumulator with UP/DOWN/BOUNCE/HOLD stepping, wrap pulse and NCH offset channels.
// count and wrap update on the stepping edge; addr follows count one cycle later.
module sig_addr_gen
  import sig_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              incr,
  input  logic [1:0]                    mode,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  input  logic                          off_we,
  input  logic [sel_width(NCH)-1:0]     off_sel,
  input  logic [WIDTH-1:0]              off_data,
  output logic [WIDTH-1:0]              count,
  output logic [NCH*WIDTH-1:0]          addr,
  output logic                          wrap
);

  localparam int SELW = sel_width(NCH);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  dir_t             dir_q, dir_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  mode_t            mode_e;

  assign mode_e = mode_t'(mode);

  // The extra MSB is the carry of the add and the borrow of the subtract.
  always_comb begin
    sum  = {1'b0, count_q} + {1'b0, incr};
    diff = {1'b0, count_q} - {1'b0, incr};
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      dir_d   = DIR_UP;
    end else if (en && (incr != '0)) begin
      unique case (mode_e)
        UP: begin
          count_d = sum[WIDTH-1:0];
          wrap_d  = sum[WIDTH];
        end
        DOWN: begin
          count_d = diff[WIDTH-1:0];
          wrap_d  = diff[WIDTH];
        end
        BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (sum[WIDTH]) begin
              count_d = '1;
              dir_d   = DIR_DN;
              wrap_d  = 1'b1;
            end else begin
              count_d = sum[WIDTH-1:0];
            end
          end else begin
            if (diff[WIDTH]) begin
              count_d = '0;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  // Selects at or above NCH match no channel, so such writes are dropped.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_offset #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .we   (off_we && (off_sel == SELW'(k))),
      .wdata(off_data),
      .count(count_q),
      .addr (addr[k*WIDTH +: WIDTH])
    );
  end

endmodule
